baud_tick_gen: RTL

Parametrised, runtime-programmable baud tick generator for the UART datapath, the successor to the fixed-count bit-time prescaler. It derives an oversample tick (`os_tick`) from `clk` using an integer plus fractional divisor. It also divides that tick by the oversample factor to produce a bit tick (`bit_tick`) and a mid-bit sample tick (`mid_tick`) for TX and RX. Divisor changes are shadowed and applied only on a tick boundary, so no output period is ever corrupted.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/baud_tick_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor calculation used to seed the baud
// tick generator's reset divisor.
package uart_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD_9600   = 9_600;
  localparam int BAUD_19200  = 19_200;
  localparam int BAUD_38400  = 38_400;
  localparam int BAUD_57600  = 57_600;
  localparam int BAUD_115200 = 115_200;
  localparam int DEF_OVS     = 16;

  // Rounded fixed-point divisor clk_hz / (baud * ovs) with frac_w fraction bits.
  function automatic int div_fixed(input int clk_hz, input int baud, input int ovs,
                                   input int frac_w);
    longint num;
    longint den;
    num = longint'(clk_hz) <<< frac_w;
    den = longint'(baud) * longint'(ovs);
    return 32'((num + den / 2) / den);
  endfunction

  function automatic int div_int_of(input int clk_hz, input int baud, input int ovs,
                                    input int frac_w);
    return div_fixed(clk_hz, baud, ovs, frac_w) >>> frac_w;
  endfunction

  function automatic int div_frac_of(input int clk_hz, input int baud, input int ovs,
                                     input int frac_w);
    return div_fixed(clk_hz, baud, ovs, frac_w) & ((1 << frac_w) - 1);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional-N oversample tick generator with bit and mid-bit ticks derived
// from the oversample phase; divisor writes are shadowed until a tick boundary.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int N            = 16,
  parameter int F            = 4,
  parameter int OVS          = DEF_OVS,
  parameter int DEFAULT_DIV  = div_int_of(CLK_HZ, BAUD_9600, OVS, F),
  parameter int DEFAULT_FRAC = div_frac_of(CLK_HZ, BAUD_9600, OVS, F),
  localparam int P           = $clog2(OVS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         restart,
  input  logic         div_wr,
  input  logic [N-1:0] div_int,
  input  logic [F-1:0] div_frac,
  output logic         os_tick,
  output logic         bit_tick,
  output logic         mid_tick,
  output logic [P-1:0] os_phase,
  output logic         div_pend,
  output logic         div_err
);

  localparam logic [N-1:0] MIN_DIV   = N'(2);
  localparam logic [P-1:0] MID_PHASE = P'(OVS / 2);

  if (OVS < 2 || OVS > 64 || (OVS & (OVS - 1)) != 0 || DEFAULT_DIV < 2) begin : g_bad_cfg
    $error("baud_tick_gen: OVS must be a power of two in 2..64 and DEFAULT_DIV >= 2");
  end

  logic [N-1:0] cnt;
  logic [F-1:0] acc;
  logic [N-1:0] act_int, pend_int;
  logic [F-1:0] act_frac, pend_frac;

  logic         wr_low;
  logic [N-1:0] wr_int;
  logic [N-1:0] eff_int;
  logic [F-1:0] eff_frac;
  logic         reload;
  logic [F:0]   acc_sum;
  logic [N-1:0] cnt_reload;
  logic [P-1:0] phase_nxt;

  // A write landing on the applying edge takes effect on that very edge.
  always_comb begin
    wr_low   = div_int < MIN_DIV;
    wr_int   = wr_low ? MIN_DIV : div_int;
    eff_int  = act_int;
    eff_frac = act_frac;
    if (div_wr) begin
      eff_int  = wr_int;
      eff_frac = div_frac;
    end else if (div_pend) begin
      eff_int  = pend_int;
      eff_frac = pend_frac;
    end
    reload     = en && (cnt == '0);
    acc_sum    = {1'b0, acc} + {1'b0, eff_frac};
    cnt_reload = eff_int - N'(1) + N'(acc_sum[F]);
    phase_nxt  = os_phase + P'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= N'(DEFAULT_DIV - 1);
      acc       <= '0;
      act_int   <= N'(DEFAULT_DIV);
      act_frac  <= F'(DEFAULT_FRAC);
      pend_int  <= N'(DEFAULT_DIV);
      pend_frac <= F'(DEFAULT_FRAC);
      div_pend  <= 1'b0;
      div_err   <= 1'b0;
      os_phase  <= '0;
      os_tick   <= 1'b0;
      bit_tick  <= 1'b0;
      mid_tick  <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;

      if (div_wr) div_err <= wr_low;

      if (restart || reload) begin
        act_int  <= eff_int;
        act_frac <= eff_frac;
        div_pend <= 1'b0;
      end else if (div_wr) begin
        pend_int  <= wr_int;
        pend_frac <= div_frac;
        div_pend  <= 1'b1;
      end

      if (restart) begin
        cnt      <= eff_int - N'(1);
        acc      <= '0;
        os_phase <= '0;
      end else if (reload) begin
        cnt      <= cnt_reload;
        acc      <= acc_sum[F-1:0];
        os_phase <= phase_nxt;
        os_tick  <= 1'b1;
        bit_tick <= (phase_nxt == '0);
        mid_tick <= (phase_nxt == MID_PHASE);
      end else if (en) begin
        cnt <= cnt - N'(1);
      end
    end
  end

endmodule
